// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and defaults for the bit-serial adder
package serial_add_pkg;

  localparam int SERIAL_ADD_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// rtl/serial_add_ctrl_fa.sv - one-bit full-adder cell used as the serial datapath
module serial_add_ctrl_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, LSB first over WIDTH cycles
// Optional subtract mode (sub port) enabled by SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: invert B and force carry-in to 1.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  serial_add_ctrl_fa u_fa (
    .x  (op_a[0]),
    .y  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts acc_nx holds the full result.
  assign acc_nx = {fa_s, acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          acc   <= acc_nx[WIDTH-1:1];
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum  <= acc_nx;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl (WIDTH=8)
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic [W:0]   exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           nc, nb, busy_seen;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=%0h required=none", {cout, sum});
        end else begin
          check("result", {23'd0, cout, sum}, {23'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc, input logic vs);
    a     = va;
    b     = vb;
    cin   = vc;
`ifdef SERIAL_ADD_SUB_EN
    sub   = vs;
`else
    if (vs) $display("note: sub ignored");
`endif
    start = 1'b1;
  endtask

  task automatic wait_done(output int n_cyc, output int n_busy);
    n_cyc  = 0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cyc++;
      if (busy) n_busy++;
      if (done) return;
    end
    n_cyc = 99;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    rst_n = 1'b1;

    // 3C + 45 = 81
    @(negedge clk);
    drive(8'h3C, 8'h45, 1'b0, 1'b0);
    exp_q.push_back(9'h081);
    @(posedge clk); #1 start = 1'b0;
    wait_done(nc, nb);
    check("lat_basic", nc, 9);
    check("busy_basic", nb, 9);
    @(negedge clk);
    check("idle_after_basic", {31'd0, busy}, 0);

    // Back-to-back with start held: FF+01 -> 100, then FF+FF+1 -> 1FF
    @(negedge clk);
    drive(8'hFF, 8'h01, 1'b0, 1'b0);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h1FF);
    @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    wait_done(nc, nb);
    check("lat_b2b_1", nc, 9);
    @(negedge clk);
    check("b2b_idle_gap", {31'd0, busy}, 0);
    @(posedge clk); #1 start = 1'b0;
    wait_done(nc, nb);
    check("lat_b2b_2", nc, 9);
    check("busy_b2b_2", nb, 9);

    // start during RUN is ignored
    @(negedge clk);
    drive(8'h01, 8'h02, 1'b0, 1'b0);
    exp_q.push_back(9'h003);
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    drive(8'hF0, 8'h0F, 1'b0, 1'b0);
    wait_done(nc, nb);
    check("lat_ignore", nc, 6);
    start = 1'b0;
    busy_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("no_second_op", busy_seen, 0);

    // Asynchronous abort mid-RUN
    @(negedge clk);
    drive(8'h55, 8'hAA, 1'b0, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_sum", {24'd0, sum}, 0);
    check("abort_cout", {31'd0, cout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(8'h10, 8'h20, 1'b0, 1'b0);
    exp_q.push_back(9'h030);
    @(posedge clk); #1 start = 1'b0;
    wait_done(nc, nb);
    check("lat_after_abort", nc, 9);

`ifdef SERIAL_ADD_SUB_EN
    @(negedge clk);
    drive(8'h10, 8'h03, 1'b0, 1'b1);
    exp_q.push_back(9'h10D);
    @(posedge clk); #1 start = 1'b0;
    wait_done(nc, nb);
    check("lat_sub1", nc, 9);
    @(negedge clk);
    drive(8'h03, 8'h10, 1'b0, 1'b1);
    exp_q.push_back(9'h0F3);
    @(posedge clk); #1 start = 1'b0;
    wait_done(nc, nb);
    check("lat_sub2", nc, 9);
    sub = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: reuses one 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands plus carry-in, LSB first.
- Trades latency for area. Intended where a multi-bit ripple adder is too large.
- Upstream logic drives it with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while in RUN or DONE
- done  output  1  one-cycle pulse; result is valid
- sum  output  WIDTH  registered result; held until the next completion
- cout  output  1  registered carry-out; held with sum

Behaviour:
- One clock (clk). Reset asynchronous, active-low (rst_n). While rst_n=0:
  - state=IDLE.
  - busy, done, sum, cout, bit counter, carry register and operand shift registers all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at the edge: opA<=a, opB<=b, carry<=cin, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, on each edge:
  - Full-adder cell computes s and c from opA[0], opB[0], carry.
  - s shifts into the MSB of the internal accumulator; opA and opB shift right by 1.
  - carry<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1: go to DONE, load sum<=final accumulator value and cout<=final carry.
- DONE: lasts exactly 1 cycle, then IDLE.
- Outputs:
  - done=1 only in DONE (Moore).
  - busy=1 in RUN and DONE.
- Latency: start accepted at edge k; done high in the cycle after edge k+WIDTH; busy high for WIDTH+1 cycles.
- start during RUN or DONE is ignored and not queued. It is re-evaluated in IDLE, so start held high from DONE launches back-to-back operations, one per WIDTH+2 cycles.
- sum/cout never show intermediate values. They change only on entry to DONE, or on reset.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1); no overflow flag.
- Counter width: $clog2(WIDTH). Wrap of cnt is never reached because the FSM leaves RUN at WIDTH-1.
- Reset mid-operation aborts immediately: no done pulse, outputs 0. The next start behaves normally.
- a, b, cin may change freely after acceptance without affecting the result.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with operands.
  - sub=1: opB loads ~b, carry loads 1 (cin ignored), giving sum = a - b. cout=1 means no borrow (a>=b, unsigned).
  - sub=0: identical to plain addition.
- Undefined: no sub port; addition only; behaviour exactly as above.

Decomposition:
- Shared package serial_add_pkg:
  - state typedef: enum logic [1:0] {IDLE=2'b00, RUN=2'b01, DONE=2'b10}.
  - SERIAL_ADD_DEFAULT_WIDTH=8.
- One sub-module: the team's existing one-bit full-adder cell, instantiated once as the serial datapath.
- FSM, counter, shift registers and output registers live in serial_add_ctrl.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> busy=0, done=0, sum=0, cout=0 without waiting for clk.
- WIDTH=8, a=8'h3C, b=8'h45, cin=0, start for 1 cycle -> busy high 9 cycles; done pulses 8 cycles after acceptance; sum=8'h81, cout=0.
- Carry edges:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
  - start held high through DONE -> second operation accepted in the following IDLE cycle.
- Ignore rule: start with a=8'h01, b=8'h02; at RUN cycle 3, assert start with a=8'hF0, b=8'h0F and change the a/b inputs -> single done; sum=8'h03; no second operation.
- Abort: rst_n low at RUN cycle 4 -> no done, outputs 0; after release, a=8'h10, b=8'h20 -> sum=8'h30.
- SERIAL_ADD_SUB_EN defined:
  - a=8'h10, b=8'h03, sub=1 -> sum=8'h0D, cout=1.
  - a=8'h03, b=8'h10, sub=1 -> sum=8'hF3, cout=0.
